mips_dmem_responder: RTL and testbench

//  Memory-side responder for the MIPS core's data-memory port: the target end of the load/store path.

---
 rtl/mips_dmem_responder.sv | 121 ++++++++++++
 tb/tb_mips_dmem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_responder.sv
// Data-memory target for the MIPS core: accepts one load/store at a time,
// holds it for WAIT_CYCLES wait states, then returns a single-cycle response.
module mips_dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic              accept;
  logic              enter_resp;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [3:0]        op_be;
  logic [IDX_W-1:0]  op_idx;
  logic              op_err;
  logic [MEM_AW-1:0] widx;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          cnt_next   = '0;
          state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == WAIT_LAST) state_next = S_RESP;
        else                  cnt_next   = cnt + 4'd1;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // With zero wait states RESP is entered on the accept edge itself, so the
  // operation must come straight from the request port rather than the latch.
  assign enter_resp = (state_next == S_RESP) && (state != S_RESP) && !rst;
  assign op_we      = (state == S_IDLE) ? req_we    : we_q;
  assign op_addr    = (state == S_IDLE) ? req_addr  : addr_q;
  assign op_wdata   = (state == S_IDLE) ? req_wdata : wdata_q;
  assign op_be      = (state == S_IDLE) ? req_be    : be_q;
  assign op_idx     = op_addr[ADDR_W-1:2];
  assign op_err     = (op_addr[1:0] != 2'b00) || (op_idx >= IDX_W'(DEPTH_WORDS));
  assign widx       = op_idx[MEM_AW-1:0];

  always_ff @(posedge clk) begin
    if (enter_resp && op_we && !op_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (op_be[i]) mem[widx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= op_err;
      rsp_rdata <= (op_we || op_err) ? '0 : mem[widx];
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench: instance 0 runs with two wait states, instance 1 with none;
// a bench-side memory model supplies every expected response.
module tb_mips_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb0 [$];
  exp_t        sb1 [$];
  logic [31:0] model [2][DEPTH];
  int          cyc     = 0;
  int          n_check = 0;
  int          n_pass  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  mips_dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_check++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int sb_size(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

  // Response monitor: pops the scoreboard and checks data, error flag and latency.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (rsp_valid[d]) begin
          exp_t e;
          if (sb_size(d) == 0) begin
            check($sformatf("unexpected_rsp%0d", d), 32'd1, 32'd0);
          end else begin
            if (d == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            check($sformatf("rdata%0d", d), rsp_rdata[d], e.rdata);
            check($sformatf("err%0d", d), 32'(rsp_err[d]), 32'(e.err));
            check($sformatf("latency%0d", d), 32'(cyc - e.acc), 32'(wait_of(d)));
          end
        end
      end
    end
  end

  task automatic push_exp(input int d, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    e.err   = addr_err(a);
    e.rdata = (we || e.err) ? 32'h0 : model[d][a[9:2]];
    e.acc   = cyc + 1;
    if (we && !e.err) begin
      for (int i = 0; i < 4; i++) if (be[i]) model[d][a[9:2]][8*i +: 8] = wd[8*i +: 8];
    end
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic wait_ready(input int d);
    int k;
    for (k = 0; k < 40 && !req_ready[d]; k++) @(negedge clk);
    if (!req_ready[d]) check($sformatf("ready_timeout%0d", d), 32'd0, 32'd1);
  endtask

  task automatic drain(input int d);
    int k;
    for (k = 0; k < 40 && sb_size(d) != 0; k++) @(negedge clk);
    if (sb_size(d) != 0) begin
      check($sformatf("rsp_timeout%0d", d), 32'(sb_size(d)), 32'd0);
      if (d == 0) sb0.delete();
      else        sb1.delete();
    end
  endtask

  // Called at a negedge; returns at a negedge once the response has been seen.
  task automatic do_req(input int d, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
    req_valid[d] = 1'b1;
    wait_ready(d);
    push_exp(d, we, a, wd, be);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_we[d] = ~we; req_addr[d] = $urandom; req_wdata[d] = $urandom; req_be[d] = 4'hF;
    drain(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      check("reset_ready", 32'(req_ready[0]), 32'd1);
      check("reset_busy", 32'(busy[0]), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check("reset_rdata", rsp_rdata[0], 32'd0);
      check("reset_err", 32'(rsp_err[0]), 32'd0);
      @(negedge clk);
    end

    for (int i = 0; i < DEPTH; i++) do_req(0, 1'b1, 32'(i * 4), 32'(i) * 32'h01010101 ^ 32'hA5C3_0F00, 4'hF);
    for (int i = 0; i < 8; i++)     do_req(1, 1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF);

    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    do_req(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'hF);
    check("model_be_merge", model[0][4], 32'hDEADBEAA);
    do_req(0, 1'b1, 32'h14, 32'h11223344, 4'b0000);
    do_req(0, 1'b1, 32'h18, 32'hCAFEF00D, 4'b1010);
    do_req(0, 1'b0, 32'h14, 32'h0, 4'h0);
    do_req(0, 1'b0, 32'h18, 32'h0, 4'h0);

    do_req(0, 1'b0, 32'h13, 32'h0, 4'hF);
    do_req(0, 1'b1, 32'h0000_0002, 32'hFFFFFFFF, 4'hF);
    do_req(0, 1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF);
    do_req(0, 1'b0, 32'(DEPTH * 4), 32'h0, 4'h0);
    for (int i = 0; i < DEPTH; i++) do_req(0, 1'b0, 32'(i * 4), 32'h0, 4'h0);

    // Store dropped by a reset during its wait states.
    req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
    req_valid[0] = 1'b1;
    wait_ready(0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("wait_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_busy", 32'(busy[0]), 32'd0);
    check("midreset_ready", 32'(req_ready[0]), 32'd1);
    repeat (5) @(negedge clk);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0);

    // Zero wait states, request held continuously.
    req_we[1] = 1'b0; req_be[1] = 4'h0; req_addr[1] = 32'h0;
    req_valid[1] = 1'b1;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      req_addr[1] = 32'(k * 4);
      wait_ready(1);
      push_exp(1, 1'b0, req_addr[1], 32'h0, 4'h0);
      if (k > 0) check("accept_spacing", 32'(sb1[sb1.size()-1].acc - prev), 32'd2);
      prev = sb1[sb1.size()-1].acc;
      @(negedge clk);
      check("ready_in_resp", 32'(req_ready[1]), 32'd0);
      check("rsp_valid_after_accept", 32'(rsp_valid[1]), 32'd1);
    end
    req_valid[1] = 1'b0;
    drain(1);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
